// File: rtl/bell_sequencer.sv
// bell_sequencer: queued multi-channel alarm bell with beep pattern, stop, limited snooze and retrigger
module bell_sequencer #(
  parameter int NCH = 4,
  parameter int LEN = 5,
  parameter int ON_TICKS = 1,
  parameter int OFF_TICKS = 1,
  parameter int SNOOZE_LEN = 3,
  parameter int MAX_SNOOZE = 2,
  parameter int CW = 32,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [NCH-1:0] trig,
  input  logic           stop,
  input  logic           snooze,
  output logic           bell,
  output logic           ringing,
  output logic           snoozing,
  output logic [CHW-1:0] chan,
  output logic [NCH-1:0] pending,
  output logic           done,
  output logic           timeout
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  localparam logic [CW-1:0] L_LEN = CW'(LEN);
  localparam logic [CW-1:0] L_ON = CW'(ON_TICKS);
  localparam logic [CW-1:0] L_OFF = CW'(OFF_TICKS);
  localparam logic [CW-1:0] L_SNZ = CW'(SNOOZE_LEN);
  localparam logic [CW-1:0] L_MAX = CW'(MAX_SNOOZE);
  state_t state;
  logic phase_on;
  logic [CW-1:0] ring_cnt, ph_cnt, snz_cnt, snz_used;
  logic [CHW-1:0] sel;
  logic [NCH-1:0] chan_mask, trig_m, clr;
  logic retrig;
  always_comb begin
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (pending[i]) sel = CHW'(i);
  end
  assign chan_mask = NCH'(1) << chan;
  // the channel in service never queues itself; in RING it extends the ring instead
  assign trig_m = trig & ~((state != IDLE) ? chan_mask : '0);
  assign clr = (state == IDLE && |pending) ? NCH'(1) << sel : '0;
  assign retrig = (state == RING) && |(trig & chan_mask);
  assign bell = (state == RING) && phase_on;
  assign ringing = (state == RING);
  assign snoozing = (state == SNOOZE);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase_on <= 1'b0;
      ring_cnt <= '0;
      ph_cnt <= '0;
      snz_cnt <= '0;
      snz_used <= '0;
      chan <= '0;
      pending <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      timeout <= 1'b0;
      pending <= (pending & ~clr) | trig_m;
      case (state)
        IDLE: if (|pending) begin
          state <= RING;
          chan <= sel;
          ring_cnt <= '0;
          phase_on <= 1'b1;
          ph_cnt <= '0;
          snz_used <= '0;
        end
        RING: if (stop) begin
          state <= IDLE;
          done <= 1'b1;
        end else if (snooze && snz_used < L_MAX) begin
          state <= SNOOZE;
          snz_cnt <= '0;
          snz_used <= snz_used + 1'b1;
        end else if (tick && !retrig && ring_cnt + 1'b1 == L_LEN) begin
          state <= IDLE;
          done <= 1'b1;
          timeout <= 1'b1;
        end else begin
          ring_cnt <= retrig ? '0 : tick ? ring_cnt + 1'b1 : ring_cnt;
          if (tick) begin
            if (phase_on && ph_cnt + 1'b1 == L_ON) begin
              ph_cnt <= '0;
              phase_on <= (OFF_TICKS == 0);
            end else if (!phase_on && ph_cnt + 1'b1 == L_OFF) begin
              ph_cnt <= '0;
              phase_on <= 1'b1;
            end else ph_cnt <= ph_cnt + 1'b1;
          end
        end
        SNOOZE: if (stop) begin
          state <= IDLE;
          done <= 1'b1;
        end else if (tick) begin
          if (snz_cnt + 1'b1 == L_SNZ) begin
            state <= RING;
            ring_cnt <= '0;
            phase_on <= 1'b1;
            ph_cnt <= '0;
          end else snz_cnt <= snz_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bell_sequencer.sv
// tb_bell_sequencer: directed self-checking bench for bell_sequencer
module tb_bell_sequencer;
  logic clk = 0, reset = 1, tick = 0, stop = 0, snooze = 0;
  logic [3:0] trig = '0;
  logic bell, ringing, snoozing, done, timeout;
  logic [1:0] chan;
  logic [3:0] pending;
  int total = 0, passed = 0;
  bell_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .trig(trig), .stop(stop), .snooze(snooze),
    .bell(bell), .ringing(ringing), .snoozing(snoozing), .chan(chan), .pending(pending),
    .done(done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic tk(input int gap = 1);
    tick = 1;
    cyc();
    tick = 0;
    cyc(gap);
  endtask
  task automatic start(input logic [3:0] t);
    trig = t;
    cyc();
    trig = '0;
    cyc();
  endtask
  logic [4:0] bell_exp;
  initial begin
    cyc(3);
    reset = 0;
    chk("rst_ring", ringing, 0);
    chk("rst_bell", bell, 0);
    chk("rst_pend", pending, 0);
    chk("rst_done", {done, timeout, snoozing, chan}, 0);
    // basic ring, tick every 4 clk
    trig = 4'b0100;
    cyc();
    trig = '0;
    chk("b_pend1", pending, 4'b0100);
    chk("b_ring1", ringing, 0);
    cyc();
    chk("b_ring2", ringing, 1);
    chk("b_chan2", chan, 2);
    chk("b_pend2", pending, 0);
    bell_exp = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b_bell%0d", i), bell, bell_exp[4-i]);
      chk($sformatf("b_rg%0d", i), ringing, 1);
      tick = 1;
      cyc();
      tick = 0;
      if (i < 4) cyc(3);
    end
    chk("b_end", {ringing, done, timeout}, 3'b011);
    cyc();
    chk("b_pulse", {done, timeout}, 0);
    // arbitration
    trig = 4'b1010;
    cyc();
    trig = '0;
    chk("a_pend", pending, 4'b1010);
    cyc();
    chk("a_chan1", {ringing, chan}, {1'b1, 2'd1});
    chk("a_pend1", pending, 4'b1000);
    stop = 1;
    cyc();
    stop = 0;
    chk("a_done", {ringing, done, timeout}, 3'b010);
    chk("a_pend2", pending, 4'b1000);
    cyc();
    chk("a_chan3", {ringing, chan}, {1'b1, 2'd3});
    chk("a_pend3", pending, 0);
    stop = 1;
    cyc();
    stop = 0;
    chk("a_done2", done, 1);
    cyc();
    // snooze
    start(4'b0001);
    chk("s_ring", {ringing, chan}, {1'b1, 2'd0});
    tk();
    tk();
    snooze = 1;
    cyc();
    snooze = 0;
    chk("s_snz1", {snoozing, ringing, bell}, 3'b100);
    tk();
    tk();
    chk("s_snz1b", snoozing, 1);
    tk();
    chk("s_back1", {ringing, bell}, 2'b11);
    tk();
    tk();
    tk();
    tk();
    chk("s_4t", ringing, 1);
    snooze = 1;
    cyc();
    snooze = 0;
    chk("s_snz2", snoozing, 1);
    tk();
    tk();
    tk();
    chk("s_back2", ringing, 1);
    snooze = 1;
    cyc();
    snooze = 0;
    chk("s_snz3_ign", {ringing, snoozing}, 2'b10);
    tk();
    tk();
    tk();
    tk();
    chk("s_still", ringing, 1);
    tick = 1;
    cyc();
    tick = 0;
    chk("s_end", {ringing, done, timeout}, 3'b011);
    cyc();
    // stop priority
    start(4'b0001);
    chk("p_ring", ringing, 1);
    {stop, snooze, tick} = 3'b111;
    cyc();
    {stop, snooze, tick} = 3'b000;
    chk("p_end", {ringing, snoozing, done, timeout}, 4'b0010);
    cyc();
    // retrigger
    start(4'b0100);
    tk();
    tk();
    tk();
    tk();
    chk("r_ring", ringing, 1);
    trig = 4'b0100;
    cyc();
    trig = '0;
    chk("r_pend", pending, 0);
    tk();
    tk();
    tk();
    tk();
    chk("r_ext", ringing, 1);
    chk("r_pend2", pending, 0);
    tick = 1;
    cyc();
    tick = 0;
    chk("r_end", {ringing, done, timeout}, 3'b011);
    cyc();
    // reset mid-operation
    start(4'b0010);
    snooze = 1;
    cyc();
    snooze = 0;
    chk("m_snz", snoozing, 1);
    trig = 4'b0001;
    cyc();
    trig = '0;
    chk("m_pend", pending, 4'b0001);
    reset = 1;
    cyc();
    reset = 0;
    chk("m_rst", {bell, ringing, snoozing, chan, pending, done, timeout}, 0);
    cyc(4);
    chk("m_idle", {ringing, pending}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
